// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - serial K-nearest-neighbour majority vote over a sorted label array
//
// Purpose: after distance_sort presents an ascending-sorted label array, latch the
// K nearest labels, build a per-class histogram one label per cycle, then scan the
// classes one per cycle to pick the winner (highest count; ties go to the class
// whose nearest member appears earliest).
//
// Ports:
//   clk                input   system clock, rising edge
//   rst                input   asynchronous reset, active low
//   valid_sort         input   sorted array valid; a rising edge starts one run
//   type_array_sorted  input   packed labels, element i at [i*TYPE_W +: TYPE_W]
//   class_out          output  winning class label (registered, held)
//   vote_count         output  votes held by class_out (registered, held)
//   valid_class        output  one-cycle pulse marking a fresh result
//   busy               output  high from start capture until DONE is left
module knn_vote #(
  parameter int L      = 5,
  parameter int TYPE_W = 3,
  parameter int K      = 5,
  parameter int CNT_W  = $clog2(K + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_sort,
  input  logic [TYPE_W*(1<<L)-1:0]    type_array_sorted,
  output logic [TYPE_W-1:0]           class_out,
  output logic [CNT_W-1:0]            vote_count,
  output logic                        valid_class,
  output logic                        busy
);

  localparam int NC    = 1 << TYPE_W;
  // Index walks 0..K-1 while counting and 0..NC while scanning (NC = finalize step).
  localparam int IDX_W = ((L > TYPE_W) ? L : TYPE_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                valid_sort_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TYPE_W-1:0]   buf_q   [K];
  logic [TYPE_W-1:0]   buf_d   [K];
  logic [CNT_W-1:0]    cnt_q   [NC];
  logic [CNT_W-1:0]    cnt_d   [NC];
  logic [CNT_W-1:0]    first_q [NC];
  logic [CNT_W-1:0]    first_d [NC];
  logic [TYPE_W-1:0]   best_cls_q, best_cls_d;
  logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
  logic [CNT_W-1:0]    best_first_q, best_first_d;
  logic [TYPE_W-1:0]   class_q, class_d;
  logic [CNT_W-1:0]    votes_q, votes_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic                start;
  logic [TYPE_W-1:0]   cur_type;
  logic [CNT_W-1:0]    scan_cnt;
  logic [CNT_W-1:0]    scan_first;

  // Elements K..N-1 are intentionally ignored.
  logic                unused_tail;
  assign unused_tail = ^type_array_sorted;

  assign start = (state_q == S_IDLE) && valid_sort && !valid_sort_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    best_cls_d   = best_cls_q;
    best_cnt_d   = best_cnt_q;
    best_first_d = best_first_q;
    class_d      = class_q;
    votes_d      = votes_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;
    cur_type     = '0;
    scan_cnt     = '0;
    scan_first   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < K; i++) begin
            buf_d[i] = type_array_sorted[i*TYPE_W +: TYPE_W];
          end
          for (int c = 0; c < NC; c++) begin
            cnt_d[c]   = '0;
            first_d[c] = CNT_W'(K);  // K encodes "not seen yet"
          end
          best_cls_d   = '0;
          best_cnt_d   = '0;
          best_first_d = CNT_W'(K);
          idx_d        = '0;
          busy_d       = 1'b1;
          state_d      = S_COUNT;
        end
      end

      S_COUNT: begin
        for (int i = 0; i < K; i++) begin
          if (idx_q == IDX_W'(i)) cur_type = buf_q[i];
        end
        for (int c = 0; c < NC; c++) begin
          if (cur_type == TYPE_W'(c)) begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
            if (first_q[c] == CNT_W'(K)) first_d[c] = CNT_W'(idx_q);
          end
        end
        if (idx_q == IDX_W'(K - 1)) begin
          idx_d   = '0;
          state_d = S_SCAN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_SCAN: begin
        if (idx_q == IDX_W'(NC)) begin
          // All classes examined: publish the running best.
          class_d = best_cls_q;
          votes_d = best_cnt_q;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          scan_cnt   = cnt_q[idx_q[TYPE_W-1:0]];
          scan_first = first_q[idx_q[TYPE_W-1:0]];
          // Empty classes carry first==K, so they can never beat the initial best.
          if ((scan_cnt > best_cnt_q) ||
              ((scan_cnt == best_cnt_q) && (scan_first < best_first_q))) begin
            best_cls_d   = idx_q[TYPE_W-1:0];
            best_cnt_d   = scan_cnt;
            best_first_d = scan_first;
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      valid_sort_q <= 1'b0;
      idx_q        <= '0;
      for (int i = 0; i < K; i++) buf_q[i] <= '0;
      for (int c = 0; c < NC; c++) begin
        cnt_q[c]   <= '0;
        first_q[c] <= '0;
      end
      best_cls_q   <= '0;
      best_cnt_q   <= '0;
      best_first_q <= '0;
      class_q      <= '0;
      votes_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_sort_q <= valid_sort;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      best_cls_q   <= best_cls_d;
      best_cnt_q   <= best_cnt_d;
      best_first_q <= best_first_d;
      class_q      <= class_d;
      votes_q      <= votes_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign class_out   = class_q;
  assign vote_count  = votes_q;
  assign valid_class = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - randomized and directed self-checking bench for knn_vote
module tb_knn_vote;

  localparam int L   = 5;
  localparam int TW  = 3;
  localparam int K   = 5;
  localparam int NC  = 1 << TW;
  localparam int N   = 1 << L;
  localparam int AW  = TW * N;
  localparam int CW  = $clog2(K + 1);
  localparam int LAT = K + NC + 1;  // edges after E0 until the result edge

  logic          clk;
  logic          rst;
  logic          valid_sort;
  logic [AW-1:0] arr;
  logic [TW-1:0] class_out;
  logic [CW-1:0] vote_count;
  logic          valid_class;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;

  // Behavioural model state
  logic          m_active = 1'b0;
  int            m_ctr    = 0;
  logic          m_prev   = 1'b0;
  logic [5:0]    m_pend   = '0;
  logic [TW-1:0] m_cls    = '0;
  logic [CW-1:0] m_cnt    = '0;

  knn_vote #(.L(L), .TYPE_W(TW), .K(K)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_sort        (valid_sort),
    .type_array_sorted (arr),
    .class_out         (class_out),
    .vote_count        (vote_count),
    .valid_class       (valid_class),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Majority over the K nearest; among tied labels, the one whose first
  // appearance is nearest wins (scan elements from far to near, keep last hit).
  function automatic logic [5:0] model_vote(input logic [AW-1:0] a);
    int counts[NC];
    int maxc;
    logic [TW-1:0] lab;
    logic [TW-1:0] win;
    for (int c = 0; c < NC; c++) counts[c] = 0;
    for (int i = 0; i < K; i++) begin
      lab = a[i*TW +: TW];
      counts[lab]++;
    end
    maxc = 0;
    for (int c = 0; c < NC; c++) if (counts[c] > maxc) maxc = counts[c];
    win = '0;
    for (int i = K - 1; i >= 0; i--) begin
      lab = a[i*TW +: TW];
      if (counts[lab] == maxc) win = lab;
    end
    return {win, 3'(maxc)};
  endfunction

  // Reference timeline: result appears LAT edges after the start edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_active = 1'b0;
        m_ctr    = 0;
        m_prev   = 1'b0;
        m_cls    = '0;
        m_cnt    = '0;
      end else begin
        if (m_active) begin
          m_ctr++;
          if (m_ctr == LAT) begin
            m_cls = m_pend[5:3];
            m_cnt = m_pend[2:0];
          end else if (m_ctr == LAT + 1) begin
            m_active = 1'b0;
          end
        end else if (valid_sort && !m_prev) begin
          m_active = 1'b1;
          m_ctr    = 0;
          m_pend   = model_vote(arr);
        end
        m_prev = valid_sort;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("busy", int'(busy), int'(m_active));
      check("valid_class", int'(valid_class), int'(m_active && (m_ctr == LAT)));
      check("class_out", int'(class_out), int'(m_cls));
      check("vote_count", int'(vote_count), int'(m_cnt));
      if (valid_class) n_pulse++;
    end
  end

  task automatic make_arr(input int e0, input int e1, input int e2, input int e3,
                          input int e4, input int tail);
    for (int i = 0; i < N; i++) begin
      arr[i*TW +: TW] = (tail < 0) ? TW'($urandom_range(0, NC - 1)) : TW'(tail);
    end
    arr[0*TW +: TW] = TW'(e0);
    arr[1*TW +: TW] = TW'(e1);
    arr[2*TW +: TW] = TW'(e2);
    arr[3*TW +: TW] = TW'(e3);
    arr[4*TW +: TW] = TW'(e4);
  endtask

  task automatic random_arr();
    for (int i = 0; i < N; i++) arr[i*TW +: TW] = TW'($urandom_range(0, NC - 1));
  endtask

  task automatic wait_valid(output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    repeat (40) begin
      @(negedge clk);
      n++;
      if (valid_class) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid: got no pulse within 40 cycles, expected one");
    end
  endtask

  task automatic start_and_wait(output int n, output logic ok);
    @(negedge clk);
    valid_sort = 1'b1;
    wait_valid(n, ok);
  endtask

  task automatic drop_and_idle();
    int guard;
    @(negedge clk);
    valid_sort = 1'b0;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_wait: busy still 1, expected 0");
    end
    @(negedge clk);
  endtask

  int   lat;
  logic ok;
  int   p0;

  initial begin
    rst        = 1'b0;
    valid_sort = 1'b0;
    arr        = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid_class), 0);
    check("reset_class", int'(class_out), 0);
    check("reset_votes", int'(vote_count), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic majority, latency and level-held valid_sort (40 cycles)
    make_arr(3, 3, 1, 4, 3, -1);
    check("model_basic", int'(model_vote(arr)), int'({3'd3, 3'd3}));
    p0 = n_pulse;
    start_and_wait(lat, ok);
    check("latency", lat, LAT + 1);
    check("basic_class", int'(class_out), 3);
    check("basic_votes", int'(vote_count), 3);
    repeat (40 - lat) @(negedge clk);
    drop_and_idle();
    check("held_pulses", n_pulse - p0, 1);

    // Tie broken by nearest first occurrence
    make_arr(2, 4, 4, 2, 5, -1);
    check("model_tie", int'(model_vote(arr)), int'({3'd2, 3'd2}));
    start_and_wait(lat, ok);
    check("tie_class", int'(class_out), 2);
    check("tie_votes", int'(vote_count), 2);
    drop_and_idle();

    // All distinct
    make_arr(5, 1, 2, 3, 4, -1);
    check("model_distinct", int'(model_vote(arr)), int'({3'd5, 3'd1}));
    start_and_wait(lat, ok);
    check("distinct_class", int'(class_out), 5);
    check("distinct_votes", int'(vote_count), 1);
    drop_and_idle();

    // Tail beyond K is ignored
    make_arr(1, 1, 2, 2, 1, 6);
    check("model_tail", int'(model_vote(arr)), int'({3'd1, 3'd3}));
    start_and_wait(lat, ok);
    check("tail_class", int'(class_out), 1);
    check("tail_votes", int'(vote_count), 3);
    drop_and_idle();

    // Re-rise while busy is ignored; re-rise after busy falls starts a new run
    random_arr();
    p0 = n_pulse;
    @(negedge clk);
    valid_sort = 1'b1;
    repeat (4) @(negedge clk);
    valid_sort = 1'b0;
    @(negedge clk);
    valid_sort = 1'b1;
    wait_valid(lat, ok);
    repeat (20) @(negedge clk);
    check("rerise_pulses", n_pulse - p0, 1);
    drop_and_idle();
    random_arr();
    p0 = n_pulse;
    start_and_wait(lat, ok);
    check("new_run_pulses", n_pulse - p0, 1);
    drop_and_idle();

    // Asynchronous reset mid-COUNT, then a clean run
    random_arr();
    @(negedge clk);
    valid_sort = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid_class), 0);
    check("abort_class", int'(class_out), 0);
    check("abort_votes", int'(vote_count), 0);
    @(negedge clk);
    valid_sort = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    make_arr(4, 4, 4, 0, 0, -1);
    start_and_wait(lat, ok);
    check("after_abort_class", int'(class_out), 4);
    check("after_abort_votes", int'(vote_count), 3);
    drop_and_idle();

    // Randomized runs checked by the model every cycle
    for (int r = 0; r < 25; r++) begin
      if (r % 3 == 0) begin
        for (int i = 0; i < N; i++) arr[i*TW +: TW] = TW'($urandom_range(0, 2));
      end else begin
        random_arr();
      end
      start_and_wait(lat, ok);
      repeat ($urandom_range(0, 15)) @(negedge clk);
      drop_and_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
